// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} arbStateT;

   localparam logic       P0         = 1'b0;
   localparam logic       P1         = 1'b1;
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic logic isMisaligned(input logic [1:0] lowBits);
      return |(lowBits & ALIGN_MASK);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant logic: a tie goes to the port that was not granted last.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic lastGrant,
   output logic grantValid,
   output logic grantPort
);

   always_comb begin
      grantValid = valid0 | valid1;
      grantPort  = P0;
      if (valid0 && valid1) begin
         grantPort = ~lastGrant;
      end else if (valid1) begin
         grantPort = P1;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory; one 3-cycle transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_we,
   input  logic [ADDR_WIDTH-1:0] p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
   output logic                  p0_rsp_err,
   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_we,
   input  logic [ADDR_WIDTH-1:0] p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
   output logic                  p1_rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   arbStateT              state, stateNext;
   logic                  latchWe, latchPort, errQ;
   logic [ADDR_WIDTH-1:0] latchAddr;
   logic [DATA_WIDTH-1:0] latchWdata, rdataQ;
   logic                  grantValid, grantPort, lastGrant, accept, aligned;

`ifdef MEM_ARB_RR_EN
   logic lastGrantQ;

   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrantQ <= P1;
      end else if (accept) begin
         lastGrantQ <= grantPort;
      end
   end

   assign lastGrant = lastGrantQ;
`else
   // Pinning the pointer to port 1 turns the round-robin picker into fixed priority.
   assign lastGrant = P1;
`endif

   mem_arb_pick uPick (
      .valid0     (p0_req_valid),
      .valid1     (p1_req_valid),
      .lastGrant  (lastGrant),
      .grantValid (grantValid),
      .grantPort  (grantPort)
   );

   assign accept  = (state == IDLE) && grantValid;
   assign aligned = ~isMisaligned(latchAddr[1:0]);

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (accept) stateNext = ACCESS;
         ACCESS:  stateNext = RESP;
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         latchWe    <= 1'b0;
         latchPort  <= P0;
         latchAddr  <= '0;
         latchWdata <= '0;
         rdataQ     <= '0;
         errQ       <= 1'b0;
      end else begin
         state <= stateNext;
         if (accept) begin
            latchPort  <= grantPort;
            latchWe    <= (grantPort == P1) ? p1_req_we    : p0_req_we;
            latchAddr  <= (grantPort == P1) ? p1_req_addr  : p0_req_addr;
            latchWdata <= (grantPort == P1) ? p1_req_wdata : p0_req_wdata;
         end
         if (state == ACCESS) begin
            errQ   <= ~aligned;
            rdataQ <= mem_re ? mem_rdata : '0;
         end
      end
   end

   assign mem_addr  = latchAddr;
   assign mem_wdata = latchWdata;
   // Reset gates the strobes so a write coinciding with reset never reaches memory.
   assign mem_we = (state == ACCESS) && latchWe && aligned && !reset;
   assign mem_re = (state == ACCESS) && !latchWe && aligned && !reset;

   assign p0_req_ready = accept && (grantPort == P0);
   assign p1_req_ready = accept && (grantPort == P1);

   assign p0_rsp_valid = (state == RESP) && (latchPort == P0);
   assign p1_rsp_valid = (state == RESP) && (latchPort == P1);
   assign p0_rsp_rdata = p0_rsp_valid ? rdataQ : '0;
   assign p1_rsp_rdata = p1_rsp_valid ? rdataQ : '0;
   assign p0_rsp_err   = p0_rsp_valid && errQ;
   assign p1_rsp_err   = p1_rsp_valid && errQ;

endmodule
